// File: rtl/mcb_port_scheduler.sv
// Burst scheduler for one MCB user port: moves whole bursts between the USB pipe FIFOs and MCB.
// Optional macro SCHED_WR_PRIORITY_EN: write always wins contention instead of round-robin.
module mcb_port_scheduler #(
    parameter int BURST_LEN = 32,
    parameter int ADDR_W    = 30,
    parameter int CNT_W     = 9
) (
    input  logic              c3_clk0,
    input  logic              rst_i,
    input  logic              c3_calib_done,
    input  logic              data_wr_req,
    input  logic              data_rd_req,
    input  logic              new_wraddr_req,
    input  logic [ADDR_W-1:0] start_wr_addr_i,
    input  logic [ADDR_W-1:0] end_wr_addr_i,
    input  logic [ADDR_W-1:0] start_rd_addr_i,
    input  logic [ADDR_W-1:0] rd_len,
    input  logic [CNT_W-1:0]  in_count,
    input  logic [63:0]       in_dout,
    output logic              in_rd_en,
    input  logic [CNT_W-1:0]  out_space,
    output logic              out_wr_en,
    output logic [63:0]       out_din,
    output logic              cmd_en,
    output logic [2:0]        cmd_instr,
    output logic [5:0]        cmd_bl,
    output logic [ADDR_W-1:0] cmd_byte_addr,
    input  logic              cmd_full,
    output logic              wr_en,
    output logic [63:0]       wr_data,
    output logic [7:0]        wr_mask,
    input  logic              wr_full,
    input  logic [6:0]        wr_count,
    output logic              rd_en,
    input  logic [63:0]       rd_data,
    input  logic              rd_empty,
    output logic              busy,
    output logic              rd_done
);
    localparam logic [ADDR_W-1:0] STEP        = ADDR_W'(BURST_LEN * 8);
    localparam logic [6:0]        LAST_BEAT   = 7'(BURST_LEN - 1);
    localparam logic [CNT_W-1:0]  BURST_WORDS = CNT_W'(BURST_LEN);

    typedef enum logic [2:0] {IDLE, WR_FILL, WR_CMD, RD_CMD, RD_DRAIN} state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W-1:0] r_rd_remaining;
    logic [6:0]        r_beat_cnt;
    logic              r_rd_req_d;
    logic              r_wa_req_d;
    logic              r_rd_pend;
    logic              r_wa_pend;
    logic              r_rd_done;

    logic              w_rd_rise;
    logic              w_wa_rise;
    logic              w_wr_elig;
    logic              w_rd_elig;
    logic              w_grant_wr;
    logic              w_grant_rd;
    logic              w_beat;
    logic              w_last_beat;
    logic [ADDR_W-1:0] w_wr_ptr_inc;

    assign w_rd_rise    = data_rd_req & ~r_rd_req_d;
    assign w_wa_rise    = new_wraddr_req & ~r_wa_req_d;
    assign w_wr_elig    = c3_calib_done & data_wr_req & (in_count >= BURST_WORDS) & (wr_count == 7'd0);
    assign w_rd_elig    = c3_calib_done & (r_rd_remaining != '0) & (out_space >= BURST_WORDS);
    assign w_last_beat  = w_beat & (r_beat_cnt == LAST_BEAT);
    assign w_wr_ptr_inc = r_wr_ptr + STEP;

`ifdef SCHED_WR_PRIORITY_EN
    assign w_grant_wr = w_wr_elig;
`else
    // Last grant remembered as "read" out of reset so the first contention goes to write.
    logic r_last_grant_rd;
    assign w_grant_wr = w_wr_elig & (~w_rd_elig | r_last_grant_rd);

    always_ff @(posedge c3_clk0 or posedge rst_i) begin
        if (rst_i) begin
            r_last_grant_rd <= 1'b1;
        end else if (r_state == IDLE && w_grant_wr) begin
            r_last_grant_rd <= 1'b0;
        end else if (r_state == IDLE && w_grant_rd) begin
            r_last_grant_rd <= 1'b1;
        end
    end
`endif
    assign w_grant_rd = w_rd_elig & ~w_grant_wr;

    assign wr_mask = 8'h00;
    assign busy    = (r_state != IDLE);
    assign rd_done = r_rd_done;

    always_comb begin
        w_state_next  = r_state;
        in_rd_en      = 1'b0;
        wr_en         = 1'b0;
        wr_data       = '0;
        rd_en         = 1'b0;
        out_wr_en     = 1'b0;
        out_din       = '0;
        cmd_en        = 1'b0;
        cmd_instr     = 3'b000;
        cmd_bl        = 6'd0;
        cmd_byte_addr = '0;
        w_beat        = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_grant_wr) begin
                    w_state_next = WR_FILL;
                end else if (w_grant_rd) begin
                    w_state_next = RD_CMD;
                end
            end
            WR_FILL: begin
                in_rd_en = ~wr_full;
                wr_en    = ~wr_full;
                wr_data  = in_dout;
                w_beat   = ~wr_full;
                if (w_last_beat) begin
                    w_state_next = WR_CMD;
                end
            end
            WR_CMD: begin
                cmd_instr     = 3'b000;
                cmd_bl        = 6'(BURST_LEN - 1);
                cmd_byte_addr = r_wr_ptr;
                cmd_en        = ~cmd_full;
                if (!cmd_full) begin
                    w_state_next = IDLE;
                end
            end
            RD_CMD: begin
                cmd_instr     = 3'b001;
                cmd_bl        = 6'(BURST_LEN - 1);
                cmd_byte_addr = r_rd_ptr;
                cmd_en        = ~cmd_full;
                if (!cmd_full) begin
                    w_state_next = RD_DRAIN;
                end
            end
            RD_DRAIN: begin
                rd_en     = ~rd_empty;
                out_wr_en = ~rd_empty;
                out_din   = rd_data;
                w_beat    = ~rd_empty;
                if (w_last_beat) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge c3_clk0 or posedge rst_i) begin
        if (rst_i) begin
            r_state        <= IDLE;
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_rd_remaining <= '0;
            r_beat_cnt     <= '0;
            r_rd_req_d     <= 1'b0;
            r_wa_req_d     <= 1'b0;
            r_rd_pend      <= 1'b0;
            r_wa_pend      <= 1'b0;
            r_rd_done      <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_rd_req_d <= data_rd_req;
            r_wa_req_d <= new_wraddr_req;
            if (w_beat) begin
                r_beat_cnt <= w_last_beat ? 7'd0 : r_beat_cnt + 7'd1;
            end
            // Pointer reloads only land between bursts; edges seen mid-burst wait here.
            if (r_state == IDLE) begin
                if (w_rd_rise || r_rd_pend) begin
                    r_rd_ptr       <= start_rd_addr_i;
                    r_rd_remaining <= rd_len;
                    r_rd_done      <= 1'b0;
                end
                if (w_wa_rise || r_wa_pend) begin
                    r_wr_ptr <= start_wr_addr_i;
                end
                r_rd_pend <= 1'b0;
                r_wa_pend <= 1'b0;
            end else begin
                if (w_rd_rise) r_rd_pend <= 1'b1;
                if (w_wa_rise) r_wa_pend <= 1'b1;
            end
            if (r_state == WR_CMD && !cmd_full) begin
                r_wr_ptr <= (w_wr_ptr_inc >= end_wr_addr_i) ? start_wr_addr_i : w_wr_ptr_inc;
            end
            if (r_state == RD_CMD && !cmd_full) begin
                r_rd_ptr       <= r_rd_ptr + STEP;
                r_rd_remaining <= r_rd_remaining - STEP;
            end
            if (r_state == RD_DRAIN && w_last_beat && r_rd_remaining == '0) begin
                r_rd_done <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mcb_port_scheduler.sv
// Randomized bench for mcb_port_scheduler: FIFO/MCB behavioural models plus a command/data scoreboard.
module tb_mcb_port_scheduler;
    localparam int BL = 32;
    localparam int AW = 30;
    localparam int CW = 9;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          c3_calib_done;
    logic          data_wr_req;
    logic          data_rd_req;
    logic          new_wraddr_req;
    logic [AW-1:0] start_wr_addr_i;
    logic [AW-1:0] end_wr_addr_i;
    logic [AW-1:0] start_rd_addr_i;
    logic [AW-1:0] rd_len;
    logic [CW-1:0] in_count;
    logic [63:0]   in_dout;
    logic          in_rd_en;
    logic [CW-1:0] out_space;
    logic          out_wr_en;
    logic [63:0]   out_din;
    logic          cmd_en;
    logic [2:0]    cmd_instr;
    logic [5:0]    cmd_bl;
    logic [AW-1:0] cmd_byte_addr;
    logic          cmd_full;
    logic          wr_en;
    logic [63:0]   wr_data;
    logic [7:0]    wr_mask;
    logic          wr_full;
    logic [6:0]    wr_count;
    logic          rd_en;
    logic [63:0]   rd_data;
    logic          rd_empty;
    logic          busy;
    logic          rd_done;

    always #5 clk = ~clk;

    mcb_port_scheduler #(.BURST_LEN(BL), .ADDR_W(AW), .CNT_W(CW)) dut (
        .c3_clk0(clk), .rst_i(rst_i), .c3_calib_done(c3_calib_done),
        .data_wr_req(data_wr_req), .data_rd_req(data_rd_req), .new_wraddr_req(new_wraddr_req),
        .start_wr_addr_i(start_wr_addr_i), .end_wr_addr_i(end_wr_addr_i),
        .start_rd_addr_i(start_rd_addr_i), .rd_len(rd_len),
        .in_count(in_count), .in_dout(in_dout), .in_rd_en(in_rd_en),
        .out_space(out_space), .out_wr_en(out_wr_en), .out_din(out_din),
        .cmd_en(cmd_en), .cmd_instr(cmd_instr), .cmd_bl(cmd_bl), .cmd_byte_addr(cmd_byte_addr),
        .cmd_full(cmd_full), .wr_en(wr_en), .wr_data(wr_data), .wr_mask(wr_mask),
        .wr_full(wr_full), .wr_count(wr_count), .rd_en(rd_en), .rd_data(rd_data),
        .rd_empty(rd_empty), .busy(busy), .rd_done(rd_done)
    );

    typedef struct {
        logic [2:0]    instr;
        logic [AW-1:0] addr;
        logic [5:0]    bl;
        int            c;
    } cmd_t;

    int            errors = 0;
    int            checks = 0;
    int            cyc = 0;
    cmd_t          cmd_log[$];
    logic [63:0]   in_q[$];
    logic [63:0]   exp_wr[$];
    logic [63:0]   wr_log[$];
    logic [63:0]   rdq[$];
    logic [63:0]   exp_rd[$];
    logic [63:0]   out_log[$];
    int            rd_lat = 0;
    bit            stall_en = 0;
    int            cmd_full_hold = 0;
    bit            stall_arm = 0;
    int            burst_beats = 0;
    int            last_wr_cyc = 0;
    logic [6:0]    wr_cnt = '0;
    int            mask_bad = 0;
    logic [AW-1:0] m_wr_ptr = '0;
    logic [AW-1:0] m_rd_ptr = '0;

    // Write ring rule: advance one burst, fall back to the ring start at or past the end.
    function automatic logic [AW-1:0] next_wr(input logic [AW-1:0] a);
        logic [AW-1:0] n;
        n = a + AW'(BL * 8);
        return (n >= end_wr_addr_i) ? start_wr_addr_i : n;
    endfunction

    function automatic int wr_mismatches();
        int bad = 0;
        for (int i = 0; i < wr_log.size(); i++)
            if (i >= exp_wr.size() || wr_log[i] !== exp_wr[i]) bad++;
        return bad;
    endfunction

    function automatic int rd_mismatches();
        int bad = 0;
        for (int i = 0; i < out_log.size(); i++)
            if (i >= exp_rd.size() || out_log[i] !== exp_rd[i]) bad++;
        return bad;
    endfunction

    task automatic consume_logs();
        int n;
        n = wr_log.size();
        for (int i = 0; i < n; i++) if (exp_wr.size() > 0) void'(exp_wr.pop_front());
        wr_log.delete();
        n = out_log.size();
        for (int i = 0; i < n; i++) if (exp_rd.size() > 0) void'(exp_rd.pop_front());
        out_log.delete();
    endtask

    task automatic push_words(input int n);
        logic [63:0] w;
        for (int i = 0; i < n; i++) begin
            w = {$urandom, $urandom};
            in_q.push_back(w);
            exp_wr.push_back(w);
        end
    endtask

    task automatic pad_cmds(input int n);
        cmd_t d;
        d.instr = 3'b111; d.addr = '1; d.bl = 6'd0; d.c = 0;
        while (cmd_log.size() < n) cmd_log.push_back(d);
    endtask

    // One clock: drive the FIFO/MCB model inputs at negedge, then observe the DUT's response.
    task automatic step();
        cmd_t c;
        logic [63:0] w;
        @(negedge clk);
        in_dout  = (in_q.size() > 0) ? in_q[0] : 64'd0;
        in_count = (in_q.size() > 511) ? CW'(511) : CW'(in_q.size());
        wr_count = wr_cnt;
        wr_full  = stall_en && ($urandom_range(0, 3) == 0);
        cmd_full = (cmd_full_hold > 0);
        if (cmd_full_hold > 0) cmd_full_hold--;
        rd_data  = (rdq.size() > 0) ? rdq[0] : 64'd0;
        rd_empty = (rdq.size() == 0) || (rd_lat > 0) || (stall_en && $urandom_range(0, 2) == 0);
        if (rd_lat > 0) rd_lat--;
        #1;
        if (wr_mask !== 8'h00) mask_bad++;
        if (in_rd_en === 1'b1 && in_q.size() > 0) void'(in_q.pop_front());
        if (wr_en === 1'b1) begin
            wr_log.push_back(wr_data);
            wr_cnt = wr_cnt + 7'd1;
            burst_beats++;
            last_wr_cyc = cyc;
            if (burst_beats == BL && stall_arm) begin
                cmd_full_hold = 5;
                stall_arm = 0;
            end
        end
        if (rd_en === 1'b1 && rdq.size() > 0) void'(rdq.pop_front());
        if (out_wr_en === 1'b1) out_log.push_back(out_din);
        if (cmd_en === 1'b1) begin
            c.instr = cmd_instr; c.addr = cmd_byte_addr; c.bl = cmd_bl; c.c = cyc;
            cmd_log.push_back(c);
            $display("cmd cyc=%0d instr=%0d bl=%0d addr=0x%0h", cyc, cmd_instr, cmd_bl, cmd_byte_addr);
            if (cmd_instr == 3'b000) begin
                wr_cnt = '0;
                burst_beats = 0;
            end else if (cmd_instr == 3'b001) begin
                for (int i = 0; i < BL; i++) begin
                    w = {$urandom, $urandom};
                    rdq.push_back(w);
                    exp_rd.push_back(w);
                end
                rd_lat = 3;
            end
        end
        cyc++;
    endtask

    task automatic run_until(input int n, input int bound, output bit ok);
        int k = 0;
        while ((cmd_log.size() < n || busy !== 1'b0) && k < bound) begin
            step();
            k++;
        end
        ok = (k < bound);
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        push_words(32);
        repeat (3) step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b want=0", busy); end
        checks++; if ({cmd_en, wr_en, in_rd_en, rd_en, out_wr_en} !== 5'b0) begin errors++;
            $display("FAIL reset_strobes got=%b want=00000", {cmd_en, wr_en, in_rd_en, rd_en, out_wr_en}); end
        checks++; if (wr_data !== 64'd0 || cmd_byte_addr !== '0) begin errors++;
            $display("FAIL reset_data got wr_data=%h addr=%h want=0", wr_data, cmd_byte_addr); end
        checks++; if (rd_done !== 1'b0) begin errors++; $display("FAIL reset_rd_done got=%0b want=0", rd_done); end
        rst_i = 1'b0;
        repeat (3) step();
        checks++; if (busy !== 1'b0 || wr_log.size() != 0) begin errors++;
            $display("FAIL idle_no_req got busy=%0b words=%0d want 0/0", busy, wr_log.size()); end
    endtask

    task automatic test_write();
        bit ok;
        c3_calib_done = 1'b0;
        data_wr_req = 1'b1;
        push_words(32);
        repeat (10) step();
        checks++; if (wr_log.size() != 0 || busy !== 1'b0) begin errors++;
            $display("FAIL calib_gate got words=%0d busy=%0b want 0/0", wr_log.size(), busy); end
        c3_calib_done = 1'b1;
        cmd_log.delete();
        run_until(2, 500, ok);
        checks++; if (!ok || cmd_log.size() != 2) begin errors++;
            $display("FAIL write_cmds got=%0d ok=%0b want=2", cmd_log.size(), ok); end
        pad_cmds(2);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (cmd_log[i].instr !== 3'b000 || cmd_log[i].bl !== 6'd31 || cmd_log[i].addr !== m_wr_ptr) begin
                errors++;
                $display("FAIL write_cmd%0d got instr=%0d bl=%0d addr=%h want 0/31/%h",
                         i, cmd_log[i].instr, cmd_log[i].bl, cmd_log[i].addr, m_wr_ptr);
            end
            m_wr_ptr = next_wr(m_wr_ptr);
        end
        checks++; if (cmd_log[1].c - cmd_log[0].c != BL + 2) begin errors++;
            $display("FAIL write_spacing got=%0d want=%0d", cmd_log[1].c - cmd_log[0].c, BL + 2); end
        checks++; if (wr_log.size() != 2 * BL || wr_mismatches() != 0) begin errors++;
            $display("FAIL write_data got words=%0d bad=%0d want %0d/0", wr_log.size(), wr_mismatches(), 2 * BL); end
        checks++; if (mask_bad != 0) begin errors++; $display("FAIL wr_mask got=%0d nonzero cycles want=0", mask_bad); end
        consume_logs();
    endtask

    task automatic test_wrap();
        bit ok;
        int k;
        logic [AW-1:0] exp_a;
        stall_en = 1;
        cmd_log.delete();
        push_words(3 * BL);
        run_until(3, 2000, ok);
        checks++; if (!ok || cmd_log.size() != 3) begin errors++;
            $display("FAIL wrap_cmds got=%0d ok=%0b want=3", cmd_log.size(), ok); end
        pad_cmds(3);
        for (int i = 0; i < 3; i++) begin
            checks++; if (cmd_log[i].addr !== m_wr_ptr) begin errors++;
                $display("FAIL wrap_addr%0d got=%h want=%h", i, cmd_log[i].addr, m_wr_ptr); end
            m_wr_ptr = next_wr(m_wr_ptr);
        end
        checks++; if (cmd_log[2].addr !== '0) begin errors++;
            $display("FAIL wrap_to_zero got=%h want=0", cmd_log[2].addr); end
        checks++; if (wr_mismatches() != 0 || wr_log.size() != 3 * BL) begin errors++;
            $display("FAIL wrap_data got words=%0d bad=%0d", wr_log.size(), wr_mismatches()); end
        consume_logs();
        // Reload while idle.
        start_wr_addr_i = 30'h200;
        new_wraddr_req = 1'b1; step(); new_wraddr_req = 1'b0;
        m_wr_ptr = start_wr_addr_i;
        cmd_log.delete();
        push_words(BL);
        run_until(1, 800, ok);
        pad_cmds(1);
        checks++; if (!ok || cmd_log[0].addr !== m_wr_ptr) begin errors++;
            $display("FAIL reload_idle got=%h want=%h", cmd_log[0].addr, m_wr_ptr); end
        m_wr_ptr = next_wr(m_wr_ptr);
        consume_logs();
        // Reload requested mid-burst is held until the burst completes.
        end_wr_addr_i = 30'h800;
        start_wr_addr_i = 30'h100;
        cmd_log.delete();
        push_words(2 * BL);
        k = 0;
        while (wr_log.size() < 5 && k < 200) begin step(); k++; end
        new_wraddr_req = 1'b1; step(); new_wraddr_req = 1'b0;
        run_until(2, 1500, ok);
        pad_cmds(2);
        exp_a = m_wr_ptr;
        checks++; if (!ok || cmd_log[0].addr !== exp_a) begin errors++;
            $display("FAIL reload_pend0 got=%h want=%h", cmd_log[0].addr, exp_a); end
        m_wr_ptr = start_wr_addr_i;
        checks++; if (cmd_log[1].addr !== m_wr_ptr) begin errors++;
            $display("FAIL reload_pend1 got=%h want=%h", cmd_log[1].addr, m_wr_ptr); end
        m_wr_ptr = next_wr(m_wr_ptr);
        consume_logs();
        end_wr_addr_i = 30'h400;
    endtask

    task automatic test_read();
        bit ok;
        int nb;
        stall_en = 1;
        data_wr_req = 1'b0;
        start_rd_addr_i = 30'h1000;
        rd_len = 30'h200;
        out_space = CW'(BL - 1);
        cmd_log.delete();
        data_rd_req = 1'b1; step(); data_rd_req = 1'b0;
        repeat (20) step();
        checks++; if (cmd_log.size() != 0 || busy !== 1'b0) begin errors++;
            $display("FAIL out_space_gate got cmds=%0d busy=%0b want 0/0", cmd_log.size(), busy); end
        checks++; if (rd_done !== 1'b0) begin errors++; $display("FAIL rd_done_early got=%0b want=0", rd_done); end
        out_space = CW'(BL);
        m_rd_ptr = start_rd_addr_i;
        nb = int'(rd_len) / (BL * 8);
        run_until(nb, 3000, ok);
        repeat (20) step();
        checks++; if (!ok || cmd_log.size() != nb) begin errors++;
            $display("FAIL read_cmds got=%0d ok=%0b want=%0d", cmd_log.size(), ok, nb); end
        pad_cmds(nb);
        for (int i = 0; i < nb; i++) begin
            checks++;
            if (cmd_log[i].instr !== 3'b001 || cmd_log[i].bl !== 6'd31 || cmd_log[i].addr !== m_rd_ptr) begin
                errors++;
                $display("FAIL read_cmd%0d got instr=%0d bl=%0d addr=%h want 1/31/%h",
                         i, cmd_log[i].instr, cmd_log[i].bl, cmd_log[i].addr, m_rd_ptr);
            end
            m_rd_ptr = m_rd_ptr + AW'(BL * 8);
        end
        checks++; if (out_log.size() != nb * BL || rd_mismatches() != 0) begin errors++;
            $display("FAIL read_data got words=%0d bad=%0d want %0d/0", out_log.size(), rd_mismatches(), nb * BL); end
        checks++; if (rd_done !== 1'b1) begin errors++; $display("FAIL rd_done got=%0b want=1", rd_done); end
        consume_logs();
    endtask

    task automatic test_contention();
        bit ok;
        logic [2:0] exp_i[12];
        logic [AW-1:0] exp_a;
        stall_en = 0;
        out_space = CW'(511);
        data_wr_req = 1'b1;
        push_words(8 * BL);
        start_rd_addr_i = 30'h2000;
        rd_len = 30'h400;
        m_rd_ptr = start_rd_addr_i;
        cmd_log.delete();
        data_rd_req = 1'b1; step(); data_rd_req = 1'b0;
        checks++; if (rd_done !== 1'b0) begin errors++; $display("FAIL rd_done_rearm got=%0b want=0", rd_done); end
        for (int i = 0; i < 12; i++) begin
`ifdef SCHED_WR_PRIORITY_EN
            exp_i[i] = (i < 8) ? 3'b000 : 3'b001;
`else
            exp_i[i] = (i < 8 && (i % 2) == 1) ? 3'b001 : 3'b000;
`endif
        end
        run_until(12, 6000, ok);
        checks++; if (!ok || cmd_log.size() != 12) begin errors++;
            $display("FAIL contend_cmds got=%0d ok=%0b want=12", cmd_log.size(), ok); end
        pad_cmds(12);
        for (int i = 0; i < 12; i++) begin
            exp_a = (exp_i[i] == 3'b000) ? m_wr_ptr : m_rd_ptr;
            checks++;
            if (cmd_log[i].instr !== exp_i[i] || cmd_log[i].addr !== exp_a) begin
                errors++;
                $display("FAIL contend%0d got instr=%0d addr=%h want %0d/%h",
                         i, cmd_log[i].instr, cmd_log[i].addr, exp_i[i], exp_a);
            end
            if (exp_i[i] == 3'b000) m_wr_ptr = next_wr(m_wr_ptr);
            else m_rd_ptr = m_rd_ptr + AW'(BL * 8);
        end
        checks++; if (wr_mismatches() != 0 || rd_mismatches() != 0 || out_log.size() != 4 * BL) begin errors++;
            $display("FAIL contend_data got wbad=%0d rbad=%0d rwords=%0d", wr_mismatches(), rd_mismatches(), out_log.size()); end
        checks++; if (rd_done !== 1'b1) begin errors++; $display("FAIL contend_rd_done got=%0b want=1", rd_done); end
        consume_logs();
    endtask

    task automatic test_stall();
        bit ok;
        stall_en = 0;
        stall_arm = 1;
        cmd_log.delete();
        push_words(BL);
        run_until(1, 500, ok);
        pad_cmds(1);
        checks++; if (!ok || cmd_log[0].c - last_wr_cyc != 6) begin errors++;
            $display("FAIL cmd_stall_delay got=%0d want=6", cmd_log[0].c - last_wr_cyc); end
        checks++; if (cmd_log[0].addr !== m_wr_ptr || cmd_log[0].instr !== 3'b000) begin errors++;
            $display("FAIL cmd_stall_addr got=%h want=%h", cmd_log[0].addr, m_wr_ptr); end
        m_wr_ptr = next_wr(m_wr_ptr);
        consume_logs();
    endtask

    task automatic test_reset_mid();
        bit ok;
        int k = 0;
        cmd_log.delete();
        push_words(BL);
        while (wr_log.size() < 10 && k < 200) begin step(); k++; end
        #2;
        rst_i = 1'b1;
        #1;
        checks++; if (wr_en !== 1'b0 || in_rd_en !== 1'b0) begin errors++;
            $display("FAIL rst_mid_wr got wr_en=%0b in_rd_en=%0b want 0/0", wr_en, in_rd_en); end
        checks++; if (busy !== 1'b0 || cmd_en !== 1'b0) begin errors++;
            $display("FAIL rst_mid_state got busy=%0b cmd_en=%0b want 0/0", busy, cmd_en); end
        checks++; if (rd_done !== 1'b0) begin errors++; $display("FAIL rst_mid_rd_done got=%0b want=0", rd_done); end
        in_q.delete(); exp_wr.delete(); wr_log.delete(); cmd_log.delete();
        rdq.delete(); exp_rd.delete(); out_log.delete();
        wr_cnt = '0; burst_beats = 0; m_wr_ptr = '0;
        repeat (2) step();
        rst_i = 1'b0;
        start_wr_addr_i = 30'h100;
        push_words(BL);
        run_until(1, 500, ok);
        pad_cmds(1);
        checks++; if (!ok || cmd_log[0].addr !== m_wr_ptr) begin errors++;
            $display("FAIL rst_mid_ptr got=%h want=%h", cmd_log[0].addr, m_wr_ptr); end
        checks++; if (wr_log.size() != BL || wr_mismatches() != 0) begin errors++;
            $display("FAIL rst_mid_data got words=%0d bad=%0d", wr_log.size(), wr_mismatches()); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        rst_i = 1'b1;
        c3_calib_done = 1'b1;
        data_wr_req = 1'b0;
        data_rd_req = 1'b0;
        new_wraddr_req = 1'b0;
        start_wr_addr_i = '0;
        end_wr_addr_i = 30'h400;
        start_rd_addr_i = '0;
        rd_len = '0;
        out_space = CW'(511);
        in_count = '0; in_dout = '0; cmd_full = 1'b0; wr_full = 1'b0;
        wr_count = '0; rd_data = '0; rd_empty = 1'b1;
        test_reset();
        test_write();
        test_wrap();
        test_read();
        test_contention();
        test_stall();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
